// File: rtl/dft_sched.sv
`default_nettype none
// dft_sched: paces ADC samples through the sliding-DFT core and writes one
// saturated magnitude per sample into a double-banked frequency BRAM.
module dft_sched #(
  parameter int SAMPLE_WIDTH = 12,
  parameter int DATA_W       = 8,
  parameter int SAMPLE_LSB   = 1,
  parameter int LIMIT_BINS   = 320,
  parameter int ADDR_W       = 9,
  parameter int ACK_TIMEOUT  = 15
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [SAMPLE_WIDTH-1:0] adc_data,
  input  logic                    adc_valid,
  input  logic                    frame_tick,
  input  logic                    dft_ready,
  input  logic [2*DATA_W-1:0]     dft_bin_out,
  output logic                    dft_start,
  output logic [DATA_W-1:0]       dft_sample,
  output logic                    dft_read,
  output logic [ADDR_W-1:0]       bin_addr,
  output logic                    bram_w_en,
  output logic [ADDR_W:0]         bram_w_addr,
  output logic [DATA_W-1:0]       bram_w_data,
  output logic                    rd_bank,
  output logic                    overrun,
  output logic                    fault
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(LIMIT_BINS - 1);

  typedef enum logic [2:0] {S_IDLE, S_ACK, S_PROC, S_CAP, S_WR} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic                pending_q, pending_d;
  logic                overrun_q, overrun_d;
  logic                fault_q, fault_d;
  logic                swap_q, swap_d;
  logic                bank_q, bank_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic                start_q, start_d;
  logic                read_q, read_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   bin_q, bin_d;
  logic [ADDR_W:0]     waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   dsample_q, dsample_d;
  logic                consume;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      sample_q  <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      fault_q   <= 1'b0;
      swap_q    <= 1'b0;
      bank_q    <= 1'b0;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      read_q    <= 1'b0;
      wen_q     <= 1'b0;
      bin_q     <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      dsample_q <= '0;
    end else begin
      state_q   <= state_d;
      sample_q  <= sample_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      fault_q   <= fault_d;
      swap_q    <= swap_d;
      bank_q    <= bank_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      read_q    <= read_d;
      wen_q     <= wen_d;
      bin_q     <= bin_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      dsample_q <= dsample_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sample_d  = sample_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    fault_d   = fault_q;
    swap_d    = swap_q | frame_tick;
    bank_d    = bank_q;
    cnt_d     = cnt_q;
    start_d   = start_q;
    read_d    = read_q;
    wen_d     = wen_q;
    bin_d     = bin_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    dsample_d = dsample_q;
    cnt_inc   = cnt_q + CNT_W'(1);
    consume   = (state_q == S_IDLE) && pending_q && dft_ready;

    // A sample arriving in the consume cycle refills the latch without loss.
    if (adc_valid) begin
      sample_d  = adc_data[SAMPLE_LSB +: DATA_W];
      pending_d = 1'b1;
      if (pending_q && !consume) overrun_d = 1'b1;
    end else if (consume) begin
      pending_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (consume) begin
          dsample_d = sample_q;
          start_d   = 1'b1;
          cnt_d     = '0;
          state_d   = S_ACK;
        end
      end
      S_ACK: begin
        if (!dft_ready) begin
          start_d = 1'b0;
          state_d = S_PROC;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(ACK_TIMEOUT)) begin
            start_d = 1'b0;
            fault_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_PROC: begin
        if (dft_ready) begin
          read_d  = 1'b1;
          state_d = S_CAP;
        end
      end
      S_CAP: begin
        read_d  = 1'b0;
        wdata_d = (|dft_bin_out[2*DATA_W-1:DATA_W]) ? '1 : dft_bin_out[DATA_W-1:0];
        waddr_d = {bank_q, bin_q};
        wen_d   = 1'b1;
        state_d = S_WR;
      end
      S_WR: begin
        wen_d = 1'b0;
        // Banks only swap at the end of a full sweep so a line never mixes sweeps.
        if (bin_q == LAST_BIN) begin
          bin_d = '0;
          if (swap_q || frame_tick) begin
            bank_d = ~bank_q;
            swap_d = 1'b0;
          end
        end else begin
          bin_d = bin_q + ADDR_W'(1);
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dft_start   = start_q;
  assign dft_sample  = dsample_q;
  assign dft_read    = read_q;
  assign bin_addr    = bin_q;
  assign bram_w_en   = wen_q;
  assign bram_w_addr = waddr_q;
  assign bram_w_data = wdata_q;
  assign rd_bank     = ~bank_q;
  assign overrun     = overrun_q;
  assign fault       = fault_q;

endmodule
`default_nettype wire

// File: doc/dft_sched.md
Name: dft_sched

Overview:
- Sequences the sliding-DFT datapath: paces ADC samples into the sdft core, runs the start/ready/read handshake, and writes one saturated 8-bit magnitude per sample into the frequency BRAM.
- The frequency BRAM is double-banked. The DFT writes one bank while the video/scroll logic reads the other. Banks swap only on a completed bin sweep that follows a frame tick, so a displayed line never mixes two sweeps.
- Sits between smpladc, sdft and freq_bram in the top level. Replaces ad-hoc FFT sequencing there.

Parameters:
- SAMPLE_WIDTH, 12, ADC sample width.
- DATA_W, 8, DFT sample width and BRAM data width.
- SAMPLE_LSB, 1, LSB index of the ADC slice fed to the DFT; the slice is adc_data[SAMPLE_LSB+DATA_W-1:SAMPLE_LSB].
- LIMIT_BINS, 320, number of bins swept, 0..LIMIT_BINS-1.
- ADDR_W, 9, bin address width.
- ACK_TIMEOUT, 15, maximum cycles to wait for dft_ready to fall after start.

Ports:
- clk  in  1  pixel clock.
- resetn  in  1  async active-low reset.
- adc_data  in  SAMPLE_WIDTH  latest ADC conversion.
- adc_valid  in  1  one-cycle pulse: new conversion on adc_data.
- frame_tick  in  1  one-cycle pulse per video frame; requests a bank swap.
- dft_ready  in  1  sdft idle/result-ready.
- dft_bin_out  in  2*DATA_W  sdft magnitude for the current bin.
- dft_start  out  1  sdft start request.
- dft_sample  out  DATA_W  sample presented to sdft.
- dft_read  out  1  one-cycle sdft read strobe.
- bin_addr  out  ADDR_W  bin currently processed (to sdft and BRAM).
- bram_w_en  out  1  BRAM write enable.
- bram_w_addr  out  ADDR_W+1  write address {wr_bank, bin}.
- bram_w_data  out  DATA_W  saturated magnitude.
- rd_bank  out  1  bank the video side must read; always ~wr_bank.
- overrun  out  1  sticky: a sample was dropped.
- fault  out  1  sticky: ACK_TIMEOUT expired.

Behaviour:
- Reset, async, any state:
  - state=IDLE.
  - All outputs 0: dft_start, dft_read, bram_w_en, bin_addr, bram_w_addr, bram_w_data, dft_sample, overrun, fault.
  - wr_bank=0, so rd_bank=1.
  - pending=0, swap_pending=0, timeout counter=0.
  - Reset mid-handshake simply abandons the transaction.
- Sample latch:
  - On adc_valid: the slice is latched into an internal sample register and pending is set.
  - adc_valid while pending=1 and not consumed that cycle: newest sample replaces the old one, overrun is set.
  - adc_valid in the same cycle as consumption: pending stays 1, no overrun.
- State IDLE:
  - If pending && dft_ready: dft_sample<=latched sample, dft_start<=1, pending<=0, counter<=0, go to ACK.
- State ACK:
  - If !dft_ready: dft_start<=0, go to PROC.
  - Else counter increments. When counter reaches ACK_TIMEOUT: dft_start<=0, fault<=1, go to IDLE. bin_addr is not advanced.
- State PROC:
  - Wait for dft_ready=1, then dft_read<=1 for exactly one cycle, go to CAP.
- State CAP:
  - dft_read<=0.
  - bram_w_data<=sat(dft_bin_out), where sat gives 8'hFF if any of bits [2*DATA_W-1:DATA_W] are set, else the low DATA_W bits.
  - bram_w_addr<={wr_bank, bin_addr}, bram_w_en<=1, go to WR.
- State WR:
  - bram_w_en<=0.
  - If bin_addr==LIMIT_BINS-1: bin_addr<=0, and if swap_pending (or frame_tick this cycle) then wr_bank toggles and swap_pending clears.
  - Else bin_addr+1. Go to IDLE.
- frame_tick sets swap_pending in any state. Multiple ticks before a wrap cause a single swap.
- Timing:
  - bram_w_en is high exactly one cycle per processed sample.
  - Minimum latency from the IDLE start decision to bram_w_en is 3 cycles plus sdft processing time.
- bin_addr is held constant from IDLE through WR.

Test Plan:
- Reset, then 3 adc_valid pulses with adc_data=12'h0AA, ideal sdft model (ready drops 1 cycle after start, rises 10 later, bin_out=16'h0042) -> 3 writes, bram_w_addr={0,0},{0,1},{0,2}, data 8'h42, dft_sample=8'h55.
- bin_out=16'h0123 -> bram_w_data=8'hFF; bin_out=16'h00FF -> 8'hFF; bin_out=16'h0000 -> 8'h00.
- 320 samples with frame_tick pulsed after sample 100 -> bank toggles right after the write at bin 319, rd_bank goes 1->0, next write at {1,0}; with no tick over the following 320 samples, no further toggle.
- Two adc_valid pulses while sdft busy in PROC -> overrun=1 and stays 1; the second sample is the one used next.
- sdft model never drops ready -> dft_start deasserts after 15 wait cycles, fault=1, state IDLE, bin_addr unchanged, no BRAM write.
- resetn pulsed low during PROC -> all outputs 0 asynchronously, bin_addr=0, wr_bank=0; after release, normal operation resumes from bin 0.
